vio_step_ctrl: RTL and testbench

VIO_STEP_CTRL -- requirements
Module: vio_step_ctrl

---
 rtl/vio_step_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vio_step_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vio_step_ctrl.sv
// Purpose: steps an analog model one time step per VIO go edge, holding its input and capturing its output.
// Latency: go_rise in cycle N -> model_cke in N+1 -> v_out_vio loaded at end of N+2+SETTLE_CYCLES.
// Backpressure: none; a go edge arriving while a step is in flight is dropped and sets sticky overrun.
module vio_step_ctrl #(
    parameter int WIDTH         = 25,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                        emu_clk,
    input  logic                        emu_rst_n,
    input  logic                        go_vio,
    input  logic                        rst_vio,
    input  logic signed [WIDTH-1:0]     v_in_vio,
    input  logic signed [WIDTH-1:0]     v_out_model,
    output logic                        model_rst,
    output logic                        model_cke,
    output logic signed [WIDTH-1:0]     v_in_model,
    output logic signed [WIDTH-1:0]     v_out_vio,
    output logic                        busy,
    output logic                        overrun,
    output logic [CNT_WIDTH-1:0]        step_count
);

    // Settle counter must hold SETTLE_CYCLES-1; keep at least one bit when SETTLE_CYCLES is 1.
    localparam int               SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [SYNC_STAGES-1:0] go_sync;
    logic [SYNC_STAGES-1:0] rst_sync;
    logic [SYNC_STAGES-1:0] prime;
    logic                   go_s;
    logic                   go_s_d;
    logic                   primed;
    logic                   armed;
    logic                   go_rise;
    logic                   accept;
    logic                   drop;
    logic [SET_W-1:0]       settle_cnt;

    // Synchronize the VIO requests. The prime chain marks when go_sync holds real
    // samples of go_vio rather than its reset fill, so a go held high through reset
    // release is never mistaken for a fresh low-to-high edge.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            go_sync  <= '0;
            rst_sync <= '1;
            prime    <= '0;
        end else begin
            go_sync  <= {go_sync[SYNC_STAGES-2:0], go_vio};
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], rst_vio};
            prime    <= {prime[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign go_s      = go_sync[SYNC_STAGES-1];
    assign primed    = prime[SYNC_STAGES-1];
    assign model_rst = rst_sync[SYNC_STAGES-1];

    // Edge detect on the synchronized go; arming waits for a genuine low sample.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            go_s_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            go_s_d <= go_s;
            if (primed && !go_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign go_rise = go_s && !go_s_d && armed;
    assign busy    = (state != IDLE);
    assign accept  = go_rise && (state == IDLE);
    assign drop    = go_rise && (state != IDLE);

    // State register.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one STEP cycle, SETTLE_CYCLES of settling, one CAPTURE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_rise) state_nxt = STEP;
            STEP:    state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Settle countdown, loaded while the model is being clocked.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            settle_cnt <= '0;
        end else if (state == STEP) begin
            settle_cnt <= SET_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_W'(1);
        end
    end

    // Model clock enable is registered so it is glitch-free and high only in STEP.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            model_cke <= 1'b0;
        end else begin
            model_cke <= (state_nxt == STEP);
        end
    end

    // Hold the model input from the accepting edge; return the settled output at CAPTURE.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            v_in_model <= '0;
            v_out_vio  <= '0;
        end else begin
            if (accept) begin
                v_in_model <= v_in_vio;
            end
            if (state == CAPTURE) begin
                v_out_vio <= v_out_model;
            end
        end
    end

    // Sticky overrun: a request landed while the previous step was still running.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

    // Step counter: cleared while the model is held in reset, wraps naturally.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            step_count <= '0;
        end else if (model_rst) begin
            step_count <= '0;
        end else if (state == STEP) begin
            step_count <= step_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_vio_step_ctrl.sv
// Purpose: scoreboard bench for vio_step_ctrl with a second 4-bit-counter instance for wrap behaviour.
// Latency: expectations are derived from go edge time, synchronizer depth and settle length.
// Backpressure: stimulus waits for each step to finish, except where overrun is deliberately provoked.
module tb_vio_step_ctrl;

    localparam int WIDTH  = 25;
    localparam int SYNC   = 2;
    localparam int SETTLE = 4;

    typedef struct {
        int                      cke_cyc;
        logic signed [WIDTH-1:0] v_in;
        logic signed [WIDTH-1:0] v_out;
        int                      cnt;
        bit                      ovr;
    } sb_t;

    logic                    emu_clk;
    logic                    emu_rst_n;
    logic                    go_vio;
    logic                    rst_vio;
    logic signed [WIDTH-1:0] v_in_vio;
    logic signed [WIDTH-1:0] v_out_model;

    logic                    model_rst;
    logic                    model_cke;
    logic signed [WIDTH-1:0] v_in_model;
    logic signed [WIDTH-1:0] v_out_vio;
    logic                    busy;
    logic                    overrun;
    logic [15:0]             step_count;

    logic                    w_model_rst;
    logic                    w_model_cke;
    logic signed [WIDTH-1:0] w_v_in_model;
    logic signed [WIDTH-1:0] w_v_out_vio;
    logic                    w_busy;
    logic                    w_overrun;
    logic [3:0]              w_step_count;

    int  cyc;
    int  n_cmp;
    int  n_bad;
    int  total_cke;
    int  model_cnt;
    bit  model_ovr;
    sb_t exp_q[$];

    vio_step_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(16)) dut (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .go_vio(go_vio), .rst_vio(rst_vio),
        .v_in_vio(v_in_vio), .v_out_model(v_out_model), .model_rst(model_rst),
        .model_cke(model_cke), .v_in_model(v_in_model), .v_out_vio(v_out_vio),
        .busy(busy), .overrun(overrun), .step_count(step_count)
    );

    vio_step_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(4)) dut_w (
        .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .go_vio(go_vio), .rst_vio(rst_vio),
        .v_in_vio(v_in_vio), .v_out_model(v_out_model), .model_rst(w_model_rst),
        .model_cke(w_model_cke), .v_in_model(w_v_in_model), .v_out_vio(w_v_out_vio),
        .busy(w_busy), .overrun(w_overrun), .step_count(w_step_count)
    );

    initial begin
        emu_clk = 1'b0;
        forever #5 emu_clk = ~emu_clk;
    end

    // A distinct model output per cycle, so the capture instant is observable.
    function automatic logic signed [WIDTH-1:0] vout_of(input int c);
        logic [31:0] h;
        h = c * 32'h0009_E377 + 32'h0123_4567;
        return WIDTH'(h);
    endfunction

    // Cycle counter and analog-model output driver.
    initial begin
        cyc         = 0;
        v_out_model = vout_of(0);
        forever begin
            @(posedge emu_clk);
            cyc = cyc + 1;
            #1 v_out_model = vout_of(cyc);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_model_rst"}, model_rst, 1);
        chk({tag, "_model_cke"}, model_cke, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_step_count"}, step_count, 0);
        chk({tag, "_step_count_w"}, w_step_count, 0);
        chk({tag, "_v_in_model"}, v_in_model, 0);
        chk({tag, "_v_out_vio"}, v_out_vio, 0);
    endtask

    // Monitor: checks each model_cke against the head entry, pops at step completion.
    initial begin
        bit busy_prev;
        bit cke_seen;
        sb_t e;
        busy_prev = 1'b0;
        cke_seen  = 1'b0;
        forever begin
            @(negedge emu_clk);
            if (!emu_rst_n) begin
                busy_prev = 1'b0;
                cke_seen  = 1'b0;
            end else begin
                if (model_cke) begin
                    total_cke = total_cke + 1;
                    if (exp_q.size() == 0) begin
                        fail("cke_without_request");
                    end else begin
                        if (cke_seen) fail("cke_twice_for_one_step");
                        cke_seen = 1'b1;
                        chk("cke_cycle", cyc, exp_q[0].cke_cyc);
                        chk("v_in_model", v_in_model, exp_q[0].v_in);
                        chk("busy_at_cke", busy, 1);
                    end
                end
                if (busy_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        fail("completion_without_request");
                    end else begin
                        e = exp_q.pop_front();
                        if (!cke_seen) fail("completion_without_cke");
                        cke_seen = 1'b0;
                        chk("done_cycle", cyc, e.cke_cyc + SETTLE + 2);
                        chk("v_out_vio", v_out_vio, e.v_out);
                        chk("step_count", step_count, e.cnt & 32'hFFFF);
                        chk("step_count_w4", w_step_count, e.cnt & 32'hF);
                        chk("overrun", overrun, e.ovr);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic set_rst(input bit v);
        @(negedge emu_clk);
        rst_vio = v;
        if (v) model_cnt = 0;
        repeat (SYNC + 3) @(negedge emu_clk);
    endtask

    // One go request; expectation pushed when go rises.
    task automatic do_step(input logic signed [WIDTH-1:0] vin, input int hold,
                           input bit second_edge, input bit mid_rst);
        int  k;
        sb_t e;
        @(negedge emu_clk);
        v_in_vio = vin;
        repeat (SYNC + 2) @(negedge emu_clk);
        k      = cyc;
        go_vio = 1'b1;
        if (mid_rst || rst_vio) model_cnt = 0;
        else                    model_cnt = model_cnt + 1;
        if (second_edge) model_ovr = 1'b1;
        e.cke_cyc = k + SYNC + 1;
        e.v_in    = vin;
        e.v_out   = vout_of(k + SYNC + 2 + SETTLE);
        e.cnt     = model_cnt;
        e.ovr     = model_ovr;
        exp_q.push_back(e);
        if (second_edge) begin
            @(negedge emu_clk) go_vio = 1'b0;
            @(negedge emu_clk) go_vio = 1'b1;
            @(negedge emu_clk) go_vio = 1'b0;
        end else begin
            repeat (hold) @(negedge emu_clk);
            go_vio = 1'b0;
        end
        if (mid_rst) begin
            while (cyc < k + SYNC + 1) @(negedge emu_clk);
            rst_vio = 1'b1;
        end
        while (cyc < k + SYNC + SETTLE + 5) @(negedge emu_clk);
    endtask

    initial begin
        int  k;
        sb_t e;
        n_cmp     = 0;
        n_bad     = 0;
        total_cke = 0;
        model_cnt = 0;
        model_ovr = 1'b0;
        emu_rst_n = 1'b0;
        go_vio    = 1'b1;
        rst_vio   = 1'b1;
        v_in_vio  = '0;

        repeat (3) @(negedge emu_clk);
        chk_reset_vals("init_reset");
        emu_rst_n = 1'b1;

        // go held high across reset release must not step.
        repeat (20) @(negedge emu_clk);
        chk("armed_no_cke", total_cke, 0);
        chk("armed_busy", busy, 0);
        go_vio = 1'b0;
        repeat (3) @(negedge emu_clk);

        // Single step with the model held in reset.
        do_step(25'sh0100000, 2, 1'b0, 1'b0);
        chk("single_cke_total", total_cke, 1);
        chk("single_model_rst", model_rst, 1);

        // 25 separated steps with the model running.
        set_rst(1'b0);
        chk("model_rst_released", model_rst, 0);
        for (int i = 0; i < 25; i++) begin
            do_step(WIDTH'($urandom), $urandom_range(1, 4), 1'b0, 1'b0);
        end
        chk("count25", step_count, 25);
        chk("count25_w4", w_step_count, 9);
        chk("count25_cke", total_cke, 26);
        chk("count25_overrun", overrun, 0);

        // Second go edge while busy is dropped and flags overrun.
        do_step(WIDTH'($urandom), 1, 1'b1, 1'b0);
        chk("overrun_cke_total", total_cke, 27);
        chk("overrun_set", overrun, 1);

        // rst_vio raised mid-step: the step still completes; counter clears.
        do_step(WIDTH'($urandom), 1, 1'b0, 1'b1);
        chk("midrst_cke_total", total_cke, 28);
        set_rst(1'b0);

        // 17 steps from zero wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            do_step(WIDTH'($urandom), $urandom_range(1, 4), 1'b0, 1'b0);
        end
        chk("wrap_w4", w_step_count, 1);
        chk("wrap_16", step_count, 17);
        chk("overrun_sticky", overrun, 1);

        // Random mix of model-reset changes and steps.
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 2) == 0) set_rst(1'(($urandom_range(0, 1))));
            do_step(WIDTH'($urandom), $urandom_range(1, 4), 1'b0, 1'b0);
        end
        set_rst(1'b0);

        // Reset asserted mid-SETTLE aborts the step with no capture.
        @(negedge emu_clk);
        v_in_vio = WIDTH'($urandom);
        repeat (SYNC + 2) @(negedge emu_clk);
        k         = cyc;
        go_vio    = 1'b1;
        e.cke_cyc = k + SYNC + 1;
        e.v_in    = v_in_vio;
        e.v_out   = '0;
        e.cnt     = 0;
        e.ovr     = 1'b0;
        exp_q.push_back(e);
        @(negedge emu_clk) go_vio = 1'b0;
        while (cyc < k + SYNC + 3) @(negedge emu_clk);
        chk("abort_busy_before", busy, 1);
        emu_rst_n = 1'b0;
        #1;
        chk_reset_vals("abort_reset");
        exp_q.delete();
        model_cnt = 0;
        model_ovr = 1'b0;
        repeat (2) @(negedge emu_clk);
        emu_rst_n = 1'b1;
        repeat (4) @(negedge emu_clk);
        chk("abort_no_capture", v_out_vio, 0);

        // First request after release is processed normally.
        do_step(WIDTH'($urandom), 2, 1'b0, 1'b0);
        chk("post_abort_count", step_count, 1);
        chk("post_abort_overrun", overrun, 0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge emu_clk);
        if (exp_q.size() != 0) fail("drain_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
